fifo_wr_arbiter: RTL and testbench

- Round-robin write-side arbiter that lets NUM_REQ producers share one synchronous FIFO write port (wr_en/wdata/full).
- Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst of up to MAX_BURST beats, then rotates.
- Sits between producer blocks and the FIFO instance and owns the FIFO write enable.

---
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ valid/ready producers
// share one synchronous FIFO write port. A grant lasts at most MAX_BURST beats,
// ends early when the owner drops valid, and every rotation costs one idle cycle.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
  output logic                          grant_valid_o,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic                          burst_done_o
);

  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                 state_q;
  logic                   grantValid_q;
  logic [ID_WIDTH-1:0]    grantId_q;
  logic [ID_WIDTH-1:0]    lastId_q;
  logic [CNT_WIDTH-1:0]   beatCnt_q;
  logic [CNT_WIDTH-1:0]   beatCnt_d;
  logic                   burstDone_q;

  logic                   ownerValid;
  logic                   beatXfer;
  logic                   releaseGrant;
  logic                   anyValid;
  logic                   winnerFound;
  logic [ID_WIDTH-1:0]    winner;
  logic [ID_WIDTH-1:0]    cand;

  // Owner's valid and the beat-transfer condition; a beat moves only when the FIFO has room
  always_comb begin
    ownerValid   = req_valid_i[grantId_q];
    beatXfer     = grantValid_q & ownerValid & ~fifo_full_i;
    beatCnt_d    = beatCnt_q + 1'b1;
    releaseGrant = grantValid_q & (~ownerValid | (beatXfer & (beatCnt_q == LAST_BEAT)));
  end

  // Round-robin search starting just after the last released owner, wrapping around
  always_comb begin
    anyValid    = |req_valid_i;
    winner      = '0;
    winnerFound = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(lastId_q) + k) % NUM_REQ);
      if (!winnerFound && req_valid_i[cand]) begin
        winner      = cand;
        winnerFound = 1'b1;
      end
    end
  end

  // Ready goes only to the current owner and is independent of its valid
  always_comb begin
    req_ready_o = '0;
    if (grantValid_q && !fifo_full_i) begin
      req_ready_o[grantId_q] = 1'b1;
    end
  end

  // Write port mux; data is held at zero whenever nobody owns the port
  always_comb begin
    fifo_wr_en_o = beatXfer;
    fifo_wdata_o = '0;
    if (grantValid_q) begin
      fifo_wdata_o = req_data_i[grantId_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant FSM: IDLE arbitrates for one cycle, GRANT counts beats and releases
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grantValid_q <= 1'b0;
      grantId_q    <= '0;
      lastId_q     <= LAST_ID;
      beatCnt_q    <= '0;
      burstDone_q  <= 1'b0;
    end else begin
      burstDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyValid) begin
            state_q      <= GRANT;
            grantValid_q <= 1'b1;
            grantId_q    <= winner;
            beatCnt_q    <= '0;
          end
        end
        GRANT: begin
          if (releaseGrant) begin
            state_q      <= IDLE;
            grantValid_q <= 1'b0;
            lastId_q     <= grantId_q;
            beatCnt_q    <= '0;
            burstDone_q  <= 1'b1;
          end else if (beatXfer) begin
            beatCnt_q <= beatCnt_d;
          end
        end
        default: begin
          state_q      <= IDLE;
          grantValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid_o = grantValid_q;
  assign grant_id_o    = grantId_q;
  assign burst_done_o  = burstDone_q;

  // Safety properties: no write into a full FIFO, at most one ready, pulse only while idle
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_wr_en_o && fifo_full_i));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) burst_done_o |-> !grant_valid_o);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized producers feed the arbiter; a transaction-level
// reference model predicts per-cycle handshake state, FIFO writes and grant order,
// and a negedge monitor pops those predictions and compares them with the DUT.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int ID_WIDTH   = 2;

  typedef struct packed {
    logic               gv;
    logic [NUM_REQ-1:0] rdy;
    logic               wr;
    logic               bd;
  } cycExp_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } wrExp_t;

  logic                          clk_i = 1'b0;
  logic                          rst_ni;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          fifo_full_i;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_wdata_o;
  logic                          grant_valid_o;
  logic [ID_WIDTH-1:0]           grant_id_o;
  logic                          burst_done_o;

  // Scoreboard queues and counters
  cycExp_t cycQ[$];
  wrExp_t  wrQ[$];
  int      grantQ[$];
  int      checks = 0;
  int      errors = 0;
  int      dutWrites = 0;
  bit      scoreOn = 1'b0;

  // Producer backlogs: each producer offers the head of its queue while non-empty
  logic [DATA_WIDTH-1:0] pend[NUM_REQ][$];

  // Reference model state: who owns the port, beats written so far, last owner
  int                    owner;
  int                    beats;
  int                    lastOwner;
  bit                    bdNext;
  logic [NUM_REQ-1:0]    curValid;
  logic [DATA_WIDTH-1:0] curData[NUM_REQ];
  bit                    curFull;
  bit                    curWr;

  // Monitor temporaries
  cycExp_t mc;
  wrExp_t  mw;
  int      mg;
  bit      prevGv = 1'b0;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .fifo_full_i(fifo_full_i),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_wdata_o(fifo_wdata_o),
    .grant_valid_o(grant_valid_o),
    .grant_id_o(grant_id_o),
    .burst_done_o(burst_done_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pendTotal();
    int t = 0;
    for (int i = 0; i < NUM_REQ; i++) t += pend[i].size();
    return t;
  endfunction

  // Model reset: nobody owns the port and the first search starts at requester 0
  task automatic releaseReset();
    rst_ni    = 1'b1;
    owner     = -1;
    beats     = 0;
    lastOwner = NUM_REQ - 1;
    bdNext    = 1'b0;
    cycQ.delete();
    wrQ.delete();
    grantQ.delete();
    scoreOn   = 1'b1;
  endtask

  // Drive one cycle of producer traffic and push the model's expectations for it
  task automatic applyStimulus(input bit gaps, input bit fullVal);
    cycExp_t e;
    wrExp_t  w;
    for (int i = 0; i < NUM_REQ; i++) begin
      curValid[i] = (pend[i].size() > 0) && (!gaps || $urandom_range(0, 9) > 1);
      curData[i]  = curValid[i] ? pend[i][0] : DATA_WIDTH'($urandom);
      req_data_i[i*DATA_WIDTH +: DATA_WIDTH] = curData[i];
    end
    req_valid_i = curValid;
    curFull     = fullVal;
    fifo_full_i = fullVal;
    curWr = (owner >= 0) && curValid[owner] && !curFull;
    e.gv  = (owner >= 0);
    e.rdy = '0;
    if (owner >= 0 && !curFull) e.rdy[owner] = 1'b1;
    e.wr  = curWr;
    e.bd  = bdNext;
    cycQ.push_back(e);
    if (curWr) begin
      w.id   = ID_WIDTH'(owner);
      w.data = curData[owner];
      wrQ.push_back(w);
    end
  endtask

  // Producers consume on the DUT handshake; the model advances by its own rules
  task automatic advanceModel();
    @(negedge clk_i);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_i[i] && req_ready_o[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    end
    bdNext = 1'b0;
    if (owner < 0) begin
      if (curValid != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (owner < 0 && curValid[(lastOwner + k) % NUM_REQ]) owner = (lastOwner + k) % NUM_REQ;
        end
        beats = 0;
        grantQ.push_back(owner);
      end
    end else begin
      if (curWr) beats++;
      if (!curValid[owner] || beats == MAX_BURST) begin
        lastOwner = owner;
        owner     = -1;
        bdNext    = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic runCycles(input int n, input bit gaps, input int fullPct, input bit refill);
    for (int c = 0; c < n; c++) begin
      if (refill && $urandom_range(0, 3) == 0) begin
        int p = $urandom_range(0, NUM_REQ - 1);
        int len = $urandom_range(1, 6);
        if (pend[p].size() < 8) begin
          for (int b = 0; b < len; b++) pend[p].push_back(DATA_WIDTH'($urandom));
        end
      end
      applyStimulus(gaps, $urandom_range(0, 99) < fullPct);
      advanceModel();
    end
  endtask

  task automatic drain(input string name, input int limit);
    int c = 0;
    while (pendTotal() > 0 && c < limit) begin
      applyStimulus(1'b0, 1'b0);
      advanceModel();
      c++;
    end
    runCycles(3, 1'b0, 0, 1'b0);
    checkOutput({name, "_drained"}, pendTotal(), 0);
  endtask

  // Monitor: per-cycle handshake state, every FIFO write, and every new grant
  always @(negedge clk_i) begin
    if (scoreOn) begin
      if (cycQ.size() == 0) begin
        checkOutput("cycle_queue_underflow", 1, 0);
      end else begin
        mc = cycQ.pop_front();
        checkOutput("grant_valid", grant_valid_o, mc.gv);
        checkOutput("req_ready", req_ready_o, mc.rdy);
        checkOutput("fifo_wr_en", fifo_wr_en_o, mc.wr);
        checkOutput("burst_done", burst_done_o, mc.bd);
      end
      if (!grant_valid_o) checkOutput("wdata_idle_zero", fifo_wdata_o, 0);
      if (fifo_wr_en_o) begin
        dutWrites++;
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          mw = wrQ.pop_front();
          checkOutput("write_id", grant_id_o, mw.id);
          checkOutput("write_data", fifo_wdata_o, mw.data);
        end
      end
      if (grant_valid_o && !prevGv) begin
        if (grantQ.size() == 0) begin
          checkOutput("unexpected_grant", 1, 0);
        end else begin
          mg = grantQ.pop_front();
          checkOutput("grant_id", grant_id_o, mg);
        end
      end
      prevGv = grant_valid_o;
    end else begin
      prevGv = 1'b0;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int loops;
    rst_ni      = 1'b0;
    req_valid_i = '1;
    req_data_i  = '1;
    fifo_full_i = 1'b0;
    owner       = -1;
    beats       = 0;
    lastOwner   = NUM_REQ - 1;
    bdNext      = 1'b0;

    // Reset holds every output low even with all requesters valid
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_grant_valid", grant_valid_o, 0);
    checkOutput("rst_fifo_wr_en", fifo_wr_en_o, 0);
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_burst_done", burst_done_o, 0);
    checkOutput("rst_grant_id", grant_id_o, 0);

    // Full rotation: all four continuously valid -> 16 writes in 20 cycles
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int b = 0; b < 8; b++) pend[i].push_back(DATA_WIDTH'(8'h40 + i*16 + b));
    end
    @(posedge clk_i);
    #1;
    releaseReset();
    base = dutWrites;
    runCycles(20, 1'b0, 0, 1'b0);
    checkOutput("rotation_writes_in_20", dutWrites - base, 16);
    drain("rotation", 100);

    // Single requester: 6 beats split as 4 + 2 with a re-grant in between
    for (int b = 0; b < 6; b++) pend[2].push_back(DATA_WIDTH'(8'h10 + b));
    base = dutWrites;
    drain("single", 40);
    checkOutput("single_writes", dutWrites - base, 6);

    // Backpressure: FIFO full for 3 cycles after beat 2 of a grant to 0
    for (int b = 0; b < 4; b++) pend[0].push_back(DATA_WIDTH'(8'hA0 + b));
    base = dutWrites;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, (c >= 3 && c <= 5));
      advanceModel();
    end
    checkOutput("backpressure_writes", dutWrites - base, 4);
    drain("backpressure", 20);

    // Early release: requester 1 sends a single beat, requester 3 follows
    pend[1].push_back(8'h51);
    for (int b = 0; b < 3; b++) pend[3].push_back(DATA_WIDTH'(8'h71 + b));
    base = dutWrites;
    drain("early_release", 40);
    checkOutput("early_release_writes", dutWrites - base, 4);

    // Async reset during beat 2 of a grant to requester 2
    for (int b = 0; b < 6; b++) pend[2].push_back(DATA_WIDTH'(8'hC0 + b));
    loops = 0;
    applyStimulus(1'b0, 1'b0);
    while (!(owner == 2 && beats == 1 && curWr) && loops < 20) begin
      advanceModel();
      applyStimulus(1'b0, 1'b0);
      loops++;
    end
    checkOutput("reach_mid_burst", (loops < 20) ? 1 : 0, 1);
    #2;
    checkOutput("mid_burst_grant_valid", grant_valid_o, 1);
    checkOutput("mid_burst_wr_en", fifo_wr_en_o, 1);
    pend[1].push_back(8'h5A);
    pend[3].push_back(8'h7A);
    rst_ni  = 1'b0;
    scoreOn = 1'b0;
    #1;
    checkOutput("async_rst_grant_valid", grant_valid_o, 0);
    checkOutput("async_rst_wr_en", fifo_wr_en_o, 0);
    checkOutput("async_rst_req_ready", req_ready_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    releaseReset();
    drain("after_async_reset", 60);

    // Randomized traffic with valid gaps and random FIFO backpressure
    runCycles(400, 1'b1, 30, 1'b1);
    drain("random", 300);

    checkOutput("write_queue_empty", wrQ.size(), 0);
    checkOutput("grant_queue_empty", grantQ.size(), 0);
    scoreOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
